// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, scan-state enum and queue entry type for the sprite scanner
package sprite_pkg;

    localparam int NUM_SPRITES = 64;
    localparam int SPR_H       = 16;
    localparam int QDEPTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

    // One queued hit as handed to the line renderer (29 bits).
    typedef struct packed {
        logic [8:0] code;
        logic [8:0] x;
        logic [3:0] row;
        logic       flip;
        logic [5:0] idx;
    } spr_entry_t;

    // Row of a sprite on a scanline; the 9-bit subtraction wraps modulo 512,
    // so sprites straddling the top of the frame still produce small rows.
    function automatic logic [8:0] sprite_row(input logic [8:0] line_no, input logic [8:0] ypos);
        return line_no - ypos;
    endfunction

endpackage

// File: rtl/spr_fifo.sv
// rtl/spr_fifo.sv - small synchronous FIFO holding sprite hits for the line renderer
module spr_fifo
    import sprite_pkg::*;
#(
    parameter int  DEPTH   = QDEPTH,
    parameter type entry_t = spr_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   empty,
    output logic   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointer/count update; a pop frees a slot for a same-cycle push even when full,
    // and a clear discards everything including that cycle's push and pop.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clr) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Status and head-of-queue view.
    always_comb begin
        dout  = mem_q[rd_q];
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
    end

endmodule

// File: rtl/sprite_scan_ctrl.sv
// rtl/sprite_scan_ctrl.sv - per-scanline sprite table scan that queues visible sprites
module sprite_scan_ctrl
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic [8:0] line,
    output logic [7:0] spr_addr,
    output logic       spr_rd,
    input  logic [7:0] spr_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_code,
    output logic [8:0] out_x,
    output logic [3:0] out_row,
    output logic       out_flip,
    output logic [5:0] out_idx,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic [4:0] hit_count
);

    scan_state_e state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [1:0]  k_q, k_d;
    logic [8:0]  line_q, line_d;
    logic [8:0]  code_q, code_d;
    logic [8:0]  ypos_q, ypos_d;
    logic [8:0]  xpos_q, xpos_d;
    logic        flip_q, flip_d;
    logic        overflow_q, overflow_d;
    logic [4:0]  hit_count_q, hit_count_d;

    logic [8:0]  row;
    logic        hit;
    logic        pop;
    logic        room;
    logic        fifo_clr;
    logic        fifo_push;
    logic        fifo_empty;
    logic        fifo_full;
    spr_entry_t  push_entry;
    spr_entry_t  head;

    spr_fifo #(
        .DEPTH   (QDEPTH),
        .entry_t (spr_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (out_ready),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Scan sequencing: four byte reads, one wait for the last byte, one compare per sprite.
    // A line_start in any state restarts the scan and wipes the previous line's results.
    always_comb begin
        row        = sprite_row(line_q, ypos_q);
        hit        = (row < 9'(SPR_H));
        pop        = !fifo_empty && out_ready;
        room       = !fifo_full || pop;
        push_entry = '{code: code_q, x: xpos_q, row: row[3:0], flip: flip_q, idx: idx_q};

        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        line_d      = line_q;
        code_d      = code_q;
        ypos_d      = ypos_q;
        xpos_d      = xpos_q;
        flip_d      = flip_q;
        overflow_d  = overflow_q;
        hit_count_d = hit_count_q;
        fifo_clr    = 1'b0;
        fifo_push   = 1'b0;

        if (line_start) begin
            line_d      = line;
            fifo_clr    = 1'b1;
            overflow_d  = 1'b0;
            hit_count_d = '0;
            idx_d       = '0;
            k_d         = '0;
            state_d     = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    // Byte k-1 arrives while byte k is being addressed.
                    unique case (k_q)
                        2'd1: code_d[7:0] = spr_data;
                        2'd2: ypos_d[7:0] = spr_data;
                        2'd3: begin
                            flip_d    = spr_data[3];
                            code_d[8] = spr_data[2];
                            xpos_d[8] = spr_data[1];
                            ypos_d[8] = spr_data[0];
                        end
                        default: begin
                        end
                    endcase
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    xpos_d[7:0] = spr_data;
                    state_d     = ST_EVAL;
                end
                ST_EVAL: begin
                    if (hit && !room) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        if (hit) begin
                            fifo_push = 1'b1;
                            // Saturates: pushes beyond the queue depth only happen when a pop made room.
                            if (hit_count_q != 5'(QDEPTH)) begin
                                hit_count_d = hit_count_q + 5'd1;
                            end
                        end
                        if (idx_q == 6'(NUM_SPRITES - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            k_d     = 2'd0;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            k_q         <= '0;
            line_q      <= '0;
            code_q      <= '0;
            ypos_q      <= '0;
            xpos_q      <= '0;
            flip_q      <= 1'b0;
            overflow_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            line_q      <= line_d;
            code_q      <= code_d;
            ypos_q      <= ypos_d;
            xpos_q      <= xpos_d;
            flip_q      <= flip_d;
            overflow_q  <= overflow_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Outputs decoded from state; payload is forced to zero while the queue is empty.
    always_comb begin
        spr_rd    = (state_q == ST_FETCH);
        spr_addr  = spr_rd ? {idx_q, k_q} : 8'd0;
        busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
        done      = (state_q == ST_DONE);
        overflow  = overflow_q;
        hit_count = hit_count_q;
        out_valid = !fifo_empty;
        out_code  = out_valid ? head.code : 9'd0;
        out_x     = out_valid ? head.x    : 9'd0;
        out_row   = out_valid ? head.row  : 4'd0;
        out_flip  = out_valid ? head.flip : 1'b0;
        out_idx   = out_valid ? head.idx  : 6'd0;
    end

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// tb/tb_sprite_scan_ctrl.sv - self-checking bench for sprite_scan_ctrl
module tb_sprite_scan_ctrl;
    import sprite_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic [8:0] line;
    logic [7:0] spr_addr;
    logic       spr_rd;
    logic [7:0] spr_data = 8'h00;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_code;
    logic [8:0] out_x;
    logic [3:0] out_row;
    logic       out_flip;
    logic [5:0] out_idx;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [4:0] hit_count;

    always #5 clk = ~clk;

    sprite_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line       (line),
        .spr_addr   (spr_addr),
        .spr_rd     (spr_rd),
        .spr_data   (spr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_x      (out_x),
        .out_row    (out_row),
        .out_flip   (out_flip),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .hit_count  (hit_count)
    );

    // Sprite RAM: one-cycle read latency, junk on the bus when not reading.
    logic [7:0] ram [256];
    always @(posedge clk) spr_data <= spr_rd ? ram[spr_addr] : 8'h5A;

    // Sprite table as seen by the bench.
    logic [8:0] ty [64];
    logic [8:0] tx [64];
    logic [8:0] tcode [64];
    logic       tflip [64];

    spr_entry_t exp_q [$];
    spr_entry_t got_q [$];
    logic       exp_ovf;
    int         exp_done;
    int         done_cnt = 0;
    int         tests = 0;
    int         fails = 0;
    spr_entry_t mon_e;

    // Record every accepted handshake and every done pulse.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !line_start) begin
            mon_e = {out_code, out_x, out_row, out_flip, out_idx};
            got_q.push_back(mon_e);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_miss(input logic [8:0] ln);
        for (int i = 0; i < 64; i++) begin
            ty[i]    = ln - 9'($urandom_range(511, 16));
            tx[i]    = 9'($urandom_range(511));
            tcode[i] = 9'($urandom_range(511));
            tflip[i] = 1'($urandom_range(1));
        end
    endtask

    task automatic set_hit(input int i, input logic [8:0] ln, input int r);
        ty[i] = ln - 9'(r);
    endtask

    task automatic load_ram();
        for (int i = 0; i < 64; i++) begin
            ram[4*i]   = tcode[i][7:0];
            ram[4*i+1] = ty[i][7:0];
            ram[4*i+2] = {4'($urandom_range(15)), tflip[i], tcode[i][8], tx[i][8], ty[i][8]};
            ram[4*i+3] = tx[i][7:0];
        end
    endtask

    // Reference: walk the table in order, keep visible sprites up to cap, stop at the first rejected hit.
    task automatic model(input logic [8:0] ln, input int cap);
        int last;
        int r;
        spr_entry_t e;
        exp_q.delete();
        exp_ovf = 1'b0;
        last = 63;
        for (int i = 0; i < 64; i++) begin
            r = (int'(ln) - int'(ty[i]) + 512) % 512;
            if (r < 16) begin
                if (exp_q.size() == cap) begin
                    exp_ovf = 1'b1;
                    last = i;
                    break;
                end
                e.code = tcode[i];
                e.x    = tx[i];
                e.row  = 4'(r);
                e.flip = tflip[i];
                e.idx  = 6'(i);
                exp_q.push_back(e);
            end
        end
        exp_done = 6 * (last + 1);
    endtask

    task automatic kick(input logic [8:0] ln);
        got_q.delete();
        @(posedge clk); #1;
        line = ln;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    // Runs from the first cycle after line_start was sampled; done_at counts edges since then.
    task automatic run_scan(input int rdy_pct, input int pulse_at, output int done_at);
        int n;
        n = 0;
        done_at = -1;
        while (n < 600 && done_at < 0) begin
            if (pulse_at >= 0) out_ready = (n == pulse_at);
            else               out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (n == 0) begin
                chk("first_fetch_rd", 32'(spr_rd), 32'd1);
                chk("first_fetch_addr", 32'(spr_addr), 32'd0);
                chk("first_fetch_busy", 32'(busy), 32'd1);
            end
            if (n == 5) chk("eval_no_rd", 32'(spr_rd), 32'd0);
            if (n == 6) chk("second_sprite_addr", 32'(spr_addr), 32'd4);
            if (done) done_at = n;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_done_pulse", 32'(done), 32'd0);
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_rd", 32'(spr_rd), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("empty_payload_zero", 32'({out_code, out_x, out_row, out_flip, out_idx}), 32'd0);
    endtask

    task automatic compare_scan(input string tag, input int done_at);
        int n_hc;
        n_hc = (exp_q.size() > 16) ? 16 : exp_q.size();
        chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({tag, " hit_count"}, 32'(hit_count), 32'(n_hc));
        chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        drain();
        chk({tag, " entries"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            chk($sformatf("%s entry%0d", tag, j), 32'(got_q[j]), 32'(exp_q[j]));
        end
    endtask

    typedef struct {
        int         s;
        logic [8:0] y;
        logic [8:0] ln;
        logic [8:0] code;
        logic [8:0] x;
        logic       flip;
        int         exp_hit;
        logic [3:0] exp_row;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        int done0;
        int act;
        int tries;
        logic [8:0] ln;
        spr_entry_t ev;

        reset = 1'b1;
        line_start = 1'b0;
        line = 9'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset spr_addr", 32'(spr_addr), 32'd0);
        chk("reset spr_rd", 32'(spr_rd), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset hit_count", 32'(hit_count), 32'd0);
        chk("reset payload", 32'({out_code, out_x, out_row, out_flip, out_idx}), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle after release", 32'(busy), 32'd0);

        // Directed single-sprite vectors: {sprite, ypos, line, code, x, flip, hit, row}
        vecs[0] = '{5,  9'h020, 9'h025, 9'h0C3, 9'h040, 1'b0, 1, 4'd5};
        vecs[1] = '{0,  9'h1FA, 9'h003, 9'h155, 9'h1FF, 1'b1, 1, 4'd9};
        vecs[2] = '{63, 9'h1F0, 9'h000, 9'h011, 9'h022, 1'b0, 0, 4'd0};
        vecs[3] = '{10, 9'h100, 9'h10F, 9'h100, 9'h101, 1'b1, 1, 4'd15};
        vecs[4] = '{20, 9'h100, 9'h110, 9'h0AA, 9'h055, 1'b0, 0, 4'd0};
        vecs[5] = '{33, 9'h050, 9'h04F, 9'h077, 9'h088, 1'b1, 0, 4'd0};
        vecs[6] = '{63, 9'h1FF, 9'h000, 9'h1AB, 9'h1CD, 1'b1, 1, 4'd1};
        for (int v = 0; v < 7; v++) begin
            fill_miss(vecs[v].ln);
            ty[vecs[v].s]    = vecs[v].y;
            tcode[vecs[v].s] = vecs[v].code;
            tx[vecs[v].s]    = vecs[v].x;
            tflip[vecs[v].s] = vecs[v].flip;
            load_ram();
            kick(vecs[v].ln);
            run_scan(0, -1, d);
            chk($sformatf("vec%0d done_cycle", v), 32'(d), 32'd384);
            chk($sformatf("vec%0d hit_count", v), 32'(hit_count), 32'(vecs[v].exp_hit));
            chk($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
            drain();
            chk($sformatf("vec%0d entries", v), 32'(got_q.size()), 32'(vecs[v].exp_hit));
            if (vecs[v].exp_hit == 1 && got_q.size() == 1) begin
                ev = '{code: vecs[v].code, x: vecs[v].x, row: vecs[v].exp_row,
                       flip: vecs[v].flip, idx: 6'(vecs[v].s)};
                chk($sformatf("vec%0d entry", v), 32'(got_q[0]), 32'(ev));
            end
        end

        // Overflow: 20 hits, renderer stalled; 17th hit at sprite 50 ends the scan.
        ln = 9'h123;
        fill_miss(ln);
        for (int k = 0; k < 20; k++) set_hit(3*k + 2, ln, k % 16);
        load_ram();
        model(ln, 16);
        kick(ln);
        run_scan(0, -1, d);
        chk("overflow done_at_306", 32'(d), 32'd306);
        compare_scan("overflow", d);

        // Full queue with a pop in the 17th hit's compare cycle: push accepted, no overflow.
        ln = 9'h0AA;
        fill_miss(ln);
        for (int i = 0; i < 17; i++) set_hit(i, ln, i % 16);
        load_ram();
        model(ln, 64);
        kick(ln);
        run_scan(0, 101, d);
        compare_scan("full_pop", d);

        // Abort mid-scan with a new line.
        fill_miss(9'h040);
        for (int i = 0; i < 64; i++) ty[i] = 9'h1C0 + 9'(i);
        for (int i = 0; i < 10; i++) set_hit(i, 9'h040, i);
        for (int i = 20; i < 26; i++) set_hit(i, 9'h080, i - 17);
        load_ram();
        done0 = done_cnt;
        kick(9'h040);
        repeat (100) @(posedge clk);
        #1;
        chk("abort pre_valid", 32'(out_valid), 32'd1);
        model(9'h080, 16);
        kick(9'h080);
        chk("abort queue_cleared", 32'(out_valid), 32'd0);
        chk("abort hit_count_cleared", 32'(hit_count), 32'd0);
        chk("abort busy", 32'(busy), 32'd1);
        run_scan(0, -1, d);
        compare_scan("abort", d);
        chk("abort done_pulses", 32'(done_cnt - done0), 32'd1);

        // Asynchronous reset in the middle of a scan.
        kick(9'h040);
        repeat (60) @(posedge clk);
        #1;
        chk("rst pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst spr_rd", 32'(spr_rd), 32'd0);
        chk("rst spr_addr", 32'(spr_addr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst hit_count", 32'(hit_count), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst payload", 32'({out_code, out_x, out_row, out_flip, out_idx}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (spr_rd || busy || out_valid || done) act++;
        end
        chk("rst quiet_after_release", 32'(act), 32'd0);

        // Random tables, renderer stalled for the whole scan.
        for (int t = 0; t < 6; t++) begin
            ln = 9'($urandom_range(511));
            fill_miss(ln);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(99) < 30) set_hit(i, ln, $urandom_range(15));
            end
            load_ram();
            model(ln, 16);
            kick(ln);
            run_scan(0, -1, d);
            compare_scan($sformatf("rand_stall%0d", t), d);
        end

        // Random tables with at most 16 hits, renderer ready at random.
        for (int t = 0; t < 6; t++) begin
            tries = 0;
            do begin
                ln = 9'($urandom_range(511));
                fill_miss(ln);
                for (int i = 0; i < 64; i++) begin
                    if ($urandom_range(99) < 15) set_hit(i, ln, $urandom_range(15));
                end
                model(ln, 64);
                tries++;
            end while (exp_q.size() > 16 && tries < 50);
            load_ram();
            kick(ln);
            run_scan(50, -1, d);
            compare_scan($sformatf("rand_ready%0d", t), d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_scan_ctrl.md
SPRITE_SCAN_CTRL -- requirements
Module: sprite_scan_ctrl

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 line_start  in  1  one-cycle pulse; begin a scan for line `line`.
REQ-004 line  in  9  target scanline, sampled when line_start=1.
REQ-005 spr_addr  out  8  sprite RAM byte address.
REQ-006 spr_rd  out  1  read strobe; data is returned on spr_data exactly one cycle later.
REQ-007 spr_data  in  8  sprite RAM read data.
REQ-008 out_valid / out_ready  out/in  1/1  valid/ready handshake to the line renderer.
REQ-009 out_code 9, out_x 9, out_row 4, out_flip 1, out_idx 6  out  payload of the head queue entry.
REQ-010 busy  out  1  scan in progress.
REQ-011 done  out  1  one-cycle pulse when a scan ends.
REQ-012 overflow  out  1  sticky per line; queue was full on a hit.
REQ-013 hit_count  out  5  hits queued this line, range 0..16.

Function
REQ-014 Sprite table: 64 entries of 4 bytes; entry i occupies bytes 4i..4i+3.
REQ-015 Entry byte layout:
- b0 = code[7:0]
- b1 = ypos[7:0]
- b2 = {-, -, -, -, flip, code[8], xpos[8], ypos[8]} (bit3..bit0)
- b3 = xpos[7:0]
REQ-016 States are IDLE, FETCH, WAIT, EVAL, DONE.
REQ-017 line_start in any state: latch `line`, clear the queue, clear overflow, clear hit_count, set i=0, enter FETCH.
REQ-018 FETCH lasts 4 cycles; cycle k drives spr_rd=1 and spr_addr=4i+k.
REQ-019 Each returned byte is captured the cycle after its address.
REQ-020 WAIT lasts 1 cycle and captures b3.
REQ-021 EVAL lasts 1 cycle; per-sprite cost is 6 cycles; a full scan is 384 cycles.
REQ-022 In EVAL, row = (line - ypos) mod 512 in 9-bit wraparound arithmetic; hit when row < 16; out_row = row[3:0].
REQ-023 On a hit with the queue not full, push {code, xpos, row[3:0], flip, i} and increment hit_count.
REQ-024 On a hit with the queue full, set overflow and go to DONE; remaining sprites are not scanned.
REQ-025 After EVAL, if i=63 go to DONE, else increment i and return to FETCH.
REQ-026 DONE pulses done for one cycle, then goes to IDLE.
REQ-027 busy=1 in FETCH, WAIT and EVAL.
REQ-028 spr_rd=0 outside FETCH.
REQ-029 Queue: 16-deep FIFO in first-in first-out order.
REQ-030 out_valid = queue not empty; a pop occurs when out_valid & out_ready.
REQ-031 A push and a pop in the same cycle are both honored, including when the queue is full.
REQ-032 "Full" for REQ-024 is evaluated after applying that cycle's pop.
REQ-033 The queue persists after DONE until drained or until the next line_start.
REQ-034 A line_start coincident with a pop: the clear wins.
REQ-035 A line_start mid-scan aborts the scan without a done pulse, then restarts per REQ-017.

Reset
REQ-036 On reset assertion: state=IDLE, i=0, queue empty.
REQ-037 On reset assertion, outputs are:
- spr_addr=0, spr_rd=0
- out_valid=0, busy=0, done=0
- overflow=0, hit_count=0
REQ-038 Payload outputs (out_code, out_x, out_row, out_flip, out_idx) are 0 while the queue is empty.
REQ-039 Reset takes effect asynchronously; release is synchronous to clk.

Structure
REQ-040 Package sprite_pkg holds:
- NUM_SPRITES=64, SPR_H=16, QDEPTH=16
- the scan-state enum
- the packed queue-entry struct {code[8:0], x[8:0], row[3:0], flip, idx[5:0]}, 29 bits
REQ-041 The FIFO is one sub-module, spr_fifo, parameterized on depth and the package entry type.
REQ-042 The FSM and the hit compare reside in sprite_scan_ctrl.

Verification
REQ-043 Single hit: only sprite 5 has ypos=0x020; line=0x025 -> one entry {idx=5, row=5}; hit_count=1; done occurs 384 cycles after line_start.
REQ-044 Wraparound: ypos=0x1FA, line=0x003 -> hit with row=9; ypos=0x1F0, line=0x000 -> no hit (row=16).
REQ-045 Overflow: 20 sprites on the line with out_ready=0 -> 16 entries (idx ascending); overflow=1; done pulses right after the 17th hit's EVAL.
REQ-046 Full plus simultaneous pop: queue full and out_ready=1 on a hit cycle -> push accepted, overflow stays 0, count stays 16.
REQ-047 Abort: line_start at cycle 100 of a scan -> queue cleared, no done pulse, fresh 384-cycle scan of the new line.
REQ-048 Reset mid-scan: all outputs 0 immediately (asynchronous), state IDLE, and no activity until the next line_start.
